// File: rtl/mul_seq_ctrl_if.sv
// rtl/mul_seq_ctrl_if.sv - request, ALU-override and response bundle for the shift-add multiply sequencer
//
// Ports (interface signals):
//   req_valid/req_ready/req_a/req_b/req_hi : multiply request handshake and operands
//   flush                                  : abort any operation
//   alu_own/alu_a_ovr/alu_rs2_ovr/alu_bsel : EX-stage ALU override driven by the sequencer
//   alu_res                                : ALU result returned combinationally
//   resp_valid/resp_ready/resp_data        : product handshake
// Modports: master = pipeline side, slave = sequencer side.
interface mul_seq_ctrl_if #(
    parameter int XLEN = 64
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            req_hi;
    logic            flush;
    logic            alu_own;
    logic [XLEN-1:0] alu_a_ovr;
    logic [XLEN-1:0] alu_rs2_ovr;
    logic [1:0]      alu_bsel;
    logic [XLEN-1:0] alu_res;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;

    modport master (
        output req_valid, req_a, req_b, req_hi, flush, alu_res, resp_ready,
        input  req_ready, alu_own, alu_a_ovr, alu_rs2_ovr, alu_bsel, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, req_hi, flush, alu_res, resp_ready,
        output req_ready, alu_own, alu_a_ovr, alu_rs2_ovr, alu_bsel, resp_valid, resp_data
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - iterative shift-add multiplier that borrows the EX-stage ALU for 64 cycles
//
// Ports:
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : mul_seq_ctrl_if.slave (request, ALU override, response)
// Optional build macro: MUL_SEQ_MULH_EN - honour req_hi and return the upper product half.
module mul_seq_ctrl #(
    parameter int XLEN = 64
) (
    input  logic           clk,
    input  logic           rstn,
    mul_seq_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [5:0]      cnt_q, cnt_d;
    logic            hi_sel_q, hi_sel_d;
    logic            req_hi_eff;
    logic            carry;

`ifdef MUL_SEQ_MULH_EN
    assign req_hi_eff = bus.req_hi;
`else
    logic unused_req_hi;
    assign unused_req_hi = bus.req_hi;
    assign req_hi_eff    = 1'b0;
`endif

    // Carry-out of hi + (mcand or 0); the sum wrapped iff it is below hi.
    assign carry = (bus.alu_res < hi_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
            hi_sel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mcand_q  <= mcand_d;
            cnt_q    <= cnt_d;
            hi_sel_q <= hi_sel_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        hi_sel_d = hi_sel_q;
        case (state_q)
            S_IDLE: begin
                if (!bus.flush && bus.req_valid) begin
                    lo_d     = bus.req_a;
                    mcand_d  = bus.req_b;
                    hi_d     = '0;
                    cnt_d    = '0;
                    hi_sel_d = req_hi_eff;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    // Shift the 2*XLEN accumulator {hi, lo} right by one, pulling in the carry.
                    hi_d  = {carry, bus.alu_res[XLEN-1:1]};
                    lo_d  = {bus.alu_res[0], lo_q[XLEN-1:1]};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd63) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.flush || bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready   = (state_q == S_IDLE);
        bus.alu_own     = (state_q == S_RUN);
        bus.alu_a_ovr   = '0;
        bus.alu_rs2_ovr = '0;
        bus.alu_bsel    = 2'b00;
        bus.resp_valid  = (state_q == S_DONE);
        bus.resp_data   = '0;
        if (state_q == S_RUN) begin
            bus.alu_a_ovr   = hi_q;
            bus.alu_rs2_ovr = mcand_q;
            bus.alu_bsel    = lo_q[0] ? 2'b01 : 2'b00;
        end
        if (state_q == S_DONE) begin
            bus.resp_data = hi_sel_q ? hi_q : lo_q;
        end
    end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - directed vector bench for mul_seq_ctrl with a behavioural EX-stage ALU
module tb_mul_seq_ctrl;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    mul_seq_ctrl_if #(.XLEN(64)) bus ();

    mul_seq_ctrl #(.XLEN(64)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // ALU forced to ADD: A operand plus B-mux output (zero or rs2).
    assign bus.alu_res = bus.alu_a_ovr + ((bus.alu_bsel == 2'b01) ? bus.alu_rs2_ovr : 64'd0);

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        hi;
        logic [63:0] exp_lo;
        logic [63:0] exp_hi;
    } vec_t;

    vec_t tbl [8];
    int   vectors = 0;
    int   errors  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".req_ready"},   64'(bus.req_ready),  64'd1);
        chk({tag, ".alu_own"},     64'(bus.alu_own),    64'd0);
        chk({tag, ".alu_bsel"},    64'(bus.alu_bsel),   64'd0);
        chk({tag, ".alu_a_ovr"},   bus.alu_a_ovr,       64'd0);
        chk({tag, ".alu_rs2_ovr"}, bus.alu_rs2_ovr,     64'd0);
        chk({tag, ".resp_valid"},  64'(bus.resp_valid), 64'd0);
        chk({tag, ".resp_data"},   bus.resp_data,       64'd0);
    endtask

    // Issue one request at a falling edge and follow it to the response.
    task automatic do_op(input string name, input logic [63:0] a, input logic [63:0] b,
                         input logic hi, input logic [63:0] exp);
        int n;
        int own_cnt;
        int b01_cnt;
        int b10_cnt;
        int lat;
        @(negedge clk);
        chk({name, ".req_ready"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_hi    = hi;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_a     = 64'hdead_0000_beef_0000;
        bus.req_b     = 64'h1111_2222_3333_4444;
        own_cnt = 0;
        b01_cnt = 0;
        b10_cnt = 0;
        lat     = -1;
        n       = 1;
        while (n < 200) begin
            if (bus.resp_valid) begin
                lat = n;
                break;
            end
            if (bus.alu_own) own_cnt++;
            if (bus.alu_bsel == 2'b01) b01_cnt++;
            if (bus.alu_bsel == 2'b10) b10_cnt++;
            @(negedge clk);
            n++;
        end
        chk({name, ".latency"},   64'(lat),     64'd65);
        chk({name, ".own_cyc"},   64'(own_cnt), 64'd64);
        chk({name, ".bsel01"},    64'(b01_cnt), 64'($countones(a)));
        chk({name, ".bsel10"},    64'(b10_cnt), 64'd0);
        chk({name, ".resp_data"}, bus.resp_data, exp);
        if (bus.resp_ready) begin
            @(negedge clk);
            chk({name, ".post_valid"}, 64'(bus.resp_valid), 64'd0);
            chk({name, ".post_ready"}, 64'(bus.req_ready),  64'd1);
        end
    endtask

    initial begin
        int seen;
        logic [63:0] exp;

        tbl[0] = '{64'd3, 64'd5, 1'b0, 64'd15, 64'd0};
        tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE};
        tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE};
        tbl[3] = '{64'd0, 64'h1234, 1'b0, 64'd0, 64'd0};
        tbl[4] = '{64'h1_0000_0000, 64'h1_0000_0000, 1'b1, 64'd0, 64'd1};
        tbl[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1};
        tbl[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'd0, 64'h4000_0000_0000_0000};
        tbl[7] = '{64'hDEAD_BEEF, 64'h10, 1'b0, 64'hD_EADB_EEF0, 64'd0};

        rstn           = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_hi     = 1'b0;
        bus.flush      = 1'b0;
        bus.resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rstn = 1'b1;

        for (int i = 0; i < 8; i++) begin
`ifdef MUL_SEQ_MULH_EN
            exp = tbl[i].hi ? tbl[i].exp_hi : tbl[i].exp_lo;
`else
            exp = tbl[i].exp_lo;
`endif
            do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].hi, exp);
        end

        // Back-pressure: result held, requests ignored while DONE waits.
        bus.resp_ready = 1'b0;
        do_op("bp", 64'd6, 64'd7, 1'b0, 64'd42);
        for (int i = 0; i < 10; i++) begin
            bus.req_valid = 1'b1;
            bus.req_a     = 64'd9;
            bus.req_b     = 64'd9;
            @(negedge clk);
            chk($sformatf("bp%0d.resp_valid", i), 64'(bus.resp_valid), 64'd1);
            chk($sformatf("bp%0d.resp_data", i),  bus.resp_data,       64'd42);
            chk($sformatf("bp%0d.req_ready", i),  64'(bus.req_ready),  64'd0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp.after_valid", 64'(bus.resp_valid), 64'd0);
        chk("bp.after_ready", 64'(bus.req_ready),  64'd1);
        @(negedge clk);
        chk("bp.no_accept", 64'(bus.alu_own), 64'd0);

        // Flush at RUN cycle 20.
        bus.req_valid = 1'b1;
        bus.req_a     = 64'h0000_FFFF;
        bus.req_b     = 64'd5;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (19) @(negedge clk);
        chk("fl.own_c20", 64'(bus.alu_own), 64'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("fl.own",        64'(bus.alu_own),    64'd0);
        chk("fl.req_ready",  64'(bus.req_ready),  64'd1);
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        chk("fl.no_resp", 64'(seen), 64'd0);
        do_op("fl.next", 64'd3, 64'd7, 1'b0, 64'd21);

        // Flush together with a request in IDLE: nothing accepted.
        @(negedge clk);
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_a     = 64'd3;
        bus.req_b     = 64'd3;
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        chk("fli.own",   64'(bus.alu_own),   64'd0);
        chk("fli.ready", 64'(bus.req_ready), 64'd1);

        // Asynchronous reset at RUN cycle 30.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_a     = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.req_b     = 64'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (29) @(negedge clk);
        chk("rst.own_c30", 64'(bus.alu_own), 64'd1);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1 chk_reset_outputs("rst_async");
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        chk("rst.no_resp", 64'(seen), 64'd0);
        do_op("rst.next", 64'd11, 64'd13, 1'b0, 64'd143);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
